// File: rtl/booth_seq_ctrl_if.sv
// Two-requester operand handshake and result channel for booth_seq_ctrl.
// The master modport is the requester/consumer side; the slave modport is the multiplier.
interface booth_seq_ctrl_if;
    logic       req0_valid;
    logic [3:0] req0_x;
    logic [3:0] req0_y;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_x;
    logic [3:0] req1_y;
    logic       req1_ready;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_z;
    logic       res_id;
    logic       busy;

    modport master (
        output req0_valid, req0_x, req0_y,
        input  req0_ready,
        output req1_valid, req1_x, req1_y,
        input  req1_ready,
        input  res_valid, res_z, res_id, busy,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_x, req0_y,
        output req0_ready,
        input  req1_valid, req1_x, req1_y,
        output req1_ready,
        output res_valid, res_z, res_id, busy,
        input  res_ready
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth 4x4 signed multiplier shared by two requesters.
// Define BOOTH_SEQ_CTRL_RR_EN for round-robin arbitration; fixed priority otherwise.
module booth_seq_ctrl (
    input  logic            clk,
    input  logic            rst,
    booth_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] x_q;
    logic [3:0] y_q;
    logic [7:0] acc;
    logic       e_q;
    logic [1:0] cnt;
    logic [7:0] res_z_q;
    logic       res_id_q;
    logic       res_valid_q;
    logic       gnt0;
    logic       gnt1;
    logic       rdy0;
    logic       rdy1;
    logic       hs;
    logic       hs_id;
    logic [7:0] y_sh;
    logic [7:0] acc_nx;

`ifdef BOOTH_SEQ_CTRL_RR_EN
    // last_id holds the requester served most recently; reset to 1 so req0 wins first
    logic last_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     last_id <= 1'b1;
        else if (hs) last_id <= hs_id;
    end

    assign gnt0 = bus.req0_valid && (!bus.req1_valid || last_id);
    assign gnt1 = bus.req1_valid && (!bus.req0_valid || !last_id);
`else
    assign gnt0 = bus.req0_valid;
    assign gnt1 = bus.req1_valid && !bus.req0_valid;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rdy0     = 1'b0;
        rdy1     = 1'b0;
        hs       = 1'b0;
        hs_id    = 1'b0;
        case (state)
            IDLE: begin
                rdy0 = gnt0;
                rdy1 = gnt1;
                if (gnt0 || gnt1) begin
                    hs       = 1'b1;
                    hs_id    = gnt1;
                    state_nx = ITER;
                end
            end
            ITER: if (cnt == 2'd3) state_nx = DONE;
            DONE: if (bus.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One Booth recoding step on bit pair {X[i], E}
    assign y_sh = {{4{y_q[3]}}, y_q} << cnt;

    always_comb begin
        acc_nx = acc;
        case ({x_q[cnt], e_q})
            2'b10:   acc_nx = acc - y_sh;
            2'b01:   acc_nx = acc + y_sh;
            default: acc_nx = acc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            acc         <= '0;
            e_q         <= 1'b0;
            cnt         <= '0;
            res_z_q     <= '0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else if (hs) begin
            x_q      <= hs_id ? bus.req1_x : bus.req0_x;
            y_q      <= hs_id ? bus.req1_y : bus.req0_y;
            res_id_q <= hs_id;
            acc      <= '0;
            e_q      <= 1'b0;
            cnt      <= '0;
        end else if (state == ITER) begin
            acc <= acc_nx;
            e_q <= x_q[cnt];
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
                res_z_q     <= acc_nx;
                res_valid_q <= 1'b1;
            end
        end else if (state == DONE && bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_z      = res_z_q;
    assign bus.res_id     = res_id_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Randomized and directed bench for booth_seq_ctrl against a plain signed-product model.
// Build with BOOTH_SEQ_CTRL_RR_EN defined to expect round-robin grants.
module tb_booth_seq_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    booth_seq_ctrl_if bus ();

    booth_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] prod(input logic [3:0] x, input logic [3:0] y);
        int xi;
        int yi;
        int p;
        xi = $signed(x);
        yi = $signed(y);
        p  = xi * yi;
        return p[7:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one request and waits for its result; lat counts edges after the accepting edge
    task automatic run_op(input bit id, input logic [3:0] x, input logic [3:0] y,
                          output logic [7:0] z, output logic rid, output int lat);
        int n;
        @(negedge clk);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_x = x; bus.req1_y = y;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_x = x; bus.req0_y = y;
        end
        #1;
        n = 0;
        while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        lat = -1;
        z   = 'x;
        rid = 1'bx;
        if (n < 20) begin
            @(posedge clk); #1;
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            bus.req0_x = 4'($urandom); bus.req0_y = 4'($urandom);
            bus.req1_x = 4'($urandom); bus.req1_y = 4'($urandom);
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                if (bus.res_valid) begin
                    lat = k;
                    break;
                end
            end
            z   = bus.res_z;
            rid = bus.res_id;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_flags valid=%b busy=%b want 0 0", bus.res_valid, bus.busy);
        end
        vectors++;
        if (bus.res_z !== 8'h00 || bus.res_id !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_res z=%h id=%b want 00 0", bus.res_z, bus.res_id);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready r0=%b r1=%b want 0 0", bus.req0_ready, bus.req1_ready);
        end
        bus.req1_valid = 1'b1;
        #1;
        vectors++;
        if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL lone_req1 r0=%b r1=%b want 0 1", bus.req0_ready, bus.req1_ready);
        end
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0] xs [3] = '{4'h3, 4'h8, 4'h7};
        logic [3:0] ys [3] = '{4'hE, 4'h8, 4'h8};
        logic [7:0] zs [3] = '{8'hFA, 8'h40, 8'hC8};
        bit         ids[3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] z;
        logic       rid;
        int         lat;
        for (int i = 0; i < 3; i++) begin
            run_op(ids[i], xs[i], ys[i], z, rid, lat);
            vectors++;
            if (z !== zs[i] || rid !== ids[i]) begin
                miscompares++;
                $display("FAIL directed%0d z=%h id=%b want %h %b", i, z, rid, zs[i], ids[i]);
            end
            // accepting edge plus four more: DONE entered on the fifth edge counted from accept
            vectors++;
            if (lat != 4) begin
                miscompares++;
                $display("FAIL latency%0d got %0d want 4", i, lat);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] x;
        logic [3:0] y;
        bit         id;
        logic [7:0] z;
        logic       rid;
        int         lat;
        for (int i = 0; i < 40; i++) begin
            x  = 4'($urandom);
            y  = 4'($urandom);
            id = 1'($urandom);
            run_op(id, x, y, z, rid, lat);
            vectors++;
            if (z !== prod(x, y) || rid !== id || lat != 4) begin
                miscompares++;
                $display("FAIL random x=%h y=%h id=%b z=%h rid=%b lat=%0d want %h %b 4",
                         x, y, id, z, rid, lat, prod(x, y), id);
            end
        end
    endtask

    task automatic test_sweep();
        logic [7:0] z;
        logic       rid;
        int         lat;
        int         bad;
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(1'b0, 4'(a), 4'(b), z, rid, lat);
                vectors++;
                if (z !== prod(4'(a), 4'(b))) begin
                    miscompares++;
                    if (bad < 8)
                        $display("FAIL sweep x=%h y=%h z=%h want %h",
                                 4'(a), 4'(b), z, prod(4'(a), 4'(b)));
                    bad++;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int   grant_id [$];
        int   grant_cyc[$];
        int   last;
        logic [7:0] exp_z[2];
        bit   exp_seq[4];
`ifdef BOOTH_SEQ_CTRL_RR_EN
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        exp_z[0] = prod(4'h3, 4'h5);
        exp_z[1] = prod(4'hD, 4'h4);
        do_reset();
        last = -1;
        bus.res_ready  = 1'b1;
        bus.req0_x = 4'h3; bus.req0_y = 4'h5;
        bus.req1_x = 4'hD; bus.req1_y = 4'h4;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int c = 0; c < 60 && grant_id.size() < 4; c++) begin
            @(negedge clk); #1;
            vectors++;
            if (bus.req0_ready && bus.req1_ready) begin
                miscompares++;
                $display("FAIL both_ready cycle %0d", c);
            end
            if (bus.res_valid && last >= 0) begin
                vectors++;
                if (bus.res_z !== exp_z[last] || bus.res_id !== 1'(last)) begin
                    miscompares++;
                    $display("FAIL b2b_result z=%h id=%b want %h %0d",
                             bus.res_z, bus.res_id, exp_z[last], last);
                end
            end
            if (bus.req0_ready || bus.req1_ready) begin
                last = bus.req1_ready ? 1 : 0;
                grant_id.push_back(last);
                grant_cyc.push_back(c);
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        vectors++;
        if (grant_id.size() != 4) begin
            miscompares++;
            $display("FAIL grant_count got %0d want 4", grant_id.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                vectors++;
                if (grant_id[g] != int'(exp_seq[g])) begin
                    miscompares++;
                    $display("FAIL grant%0d got %0d want %0d", g, grant_id[g], exp_seq[g]);
                end
            end
            for (int g = 1; g < 4; g++) begin
                vectors++;
                if (grant_cyc[g] - grant_cyc[g-1] != 6) begin
                    miscompares++;
                    $display("FAIL spacing%0d got %0d want 6", g,
                             grant_cyc[g] - grant_cyc[g-1]);
                end
            end
        end
        repeat (8) @(posedge clk);
    endtask

    task automatic test_stall();
        logic [7:0] z;
        logic       rid;
        int         lat;
        logic [7:0] want;
        int         bad;
        want = prod(4'h5, 4'hD);
        bus.res_ready = 1'b0;
        run_op(1'b0, 4'h5, 4'hD, z, rid, lat);
        vectors++;
        if (z !== want || lat != 4) begin
            miscompares++;
            $display("FAIL stall_first z=%h lat=%0d want %h 4", z, lat, want);
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.res_z !== want || bus.res_id !== 1'b0 || bus.busy !== 1'b1 ||
                bus.res_valid !== 1'b1 || bus.req0_ready !== 1'b0 ||
                bus.req1_ready !== 1'b0) begin
                miscompares++;
                if (bad < 3)
                    $display("FAIL stall%0d z=%h id=%b busy=%b v=%b r0=%b r1=%b want %h 0 1 1 0 0",
                             c, bus.res_z, bus.res_id, bus.busy, bus.res_valid,
                             bus.req0_ready, bus.req1_ready, want);
                bad++;
            end
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_z !== want) begin
            miscompares++;
            $display("FAIL stall_release busy=%b v=%b z=%h want 0 0 %h",
                     bus.busy, bus.res_valid, bus.res_z, want);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_x = 4'h3;
        bus.req0_y = 4'h3;
        #1;
        vectors++;
        if (bus.req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_accept r0=%b want 1", bus.req0_ready);
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_async busy=%b v=%b want 0 0", bus.busy, bus.res_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.res_valid || bus.busy) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL midrst_ghost result or busy after release, want none");
        end
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        vectors++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_grant r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_x     = 4'h0;
        bus.req0_y     = 4'h0;
        bus.req1_valid = 1'b0;
        bus.req1_x     = 4'h0;
        bus.req1_y     = 4'h0;
        bus.res_ready  = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_sweep();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
